mod12_wrap_tracker: RTL and testbench

- Downstream consumer of the mod-12 loadable up/down counter.
- Samples the counter's dout every clock and classifies each step: hold, increment, decrement, wrap, load, or illegal.
- Keeps a signed epoch count of completed wraps and an AM/PM-style half flag.
- Flags out-of-range values and illegal jumps, so the scoreboard and system logic can trust the count stream.

---
 rtl/counter_pkg.sv | 21 ++
 rtl/mod12_step_classifier.sv | 40 ++++
 rtl/mod12_wrap_tracker.sv | 109 ++++++++++
 tb/tb_mod12_wrap_tracker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and types for the mod-12 counter and its downstream tracker.
package counter_pkg;

  localparam logic [3:0] MOD12_MAX = 4'd11;

  typedef enum logic [2:0] {
    STEP_HOLD,
    STEP_INC,
    STEP_DEC,
    STEP_WRAP_UP,
    STEP_WRAP_DN,
    STEP_LOAD,
    STEP_ILLEGAL
  } step_e;

  typedef enum logic {
    ST_INIT,
    ST_TRACK
  } trk_state_e;

endpackage

// File: rtl/mod12_step_classifier.sv
// Combinational classification of one counter step (prev -> dout) given the aligned load flag.
module mod12_step_classifier
  import counter_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int MOD_MAX = int'(MOD12_MAX)
) (
  input  logic [CNT_W-1:0] i_prev,
  input  logic [CNT_W-1:0] i_dout,
  input  logic             i_load_q,
  output step_e            o_step
);

  // One extra bit so prev+1 / prev-1 never alias through the top of the range.
  localparam logic [CNT_W:0] MAX_X = (CNT_W+1)'(MOD_MAX);
  localparam logic [CNT_W:0] ONE_X = (CNT_W+1)'(1);

  logic [CNT_W:0] w_prev_x;
  logic [CNT_W:0] w_dout_x;

  assign w_prev_x = {1'b0, i_prev};
  assign w_dout_x = {1'b0, i_dout};

  always_comb begin
    o_step = STEP_ILLEGAL;
    if (i_load_q)
      o_step = STEP_LOAD;
    else if (w_dout_x == w_prev_x)
      o_step = STEP_HOLD;
    else if (w_prev_x == MAX_X && w_dout_x == '0)
      o_step = STEP_WRAP_UP;
    else if (w_prev_x == '0 && w_dout_x == MAX_X)
      o_step = STEP_WRAP_DN;
    else if (w_dout_x == w_prev_x + ONE_X)
      o_step = STEP_INC;
    else if (w_dout_x + ONE_X == w_prev_x)
      o_step = STEP_DEC;
  end

endmodule

// File: rtl/mod12_wrap_tracker.sv
// Watches the mod-12 counter output, pulses on wraps, keeps a signed epoch and half flag,
// and raises sticky flags for out-of-range values and impossible jumps.
module mod12_wrap_tracker
  import counter_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int MOD_MAX = int'(MOD12_MAX),
  parameter int EPOCH_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CNT_W-1:0]          dout,
  input  logic                      load,
  input  logic                      clr_err,
  output logic                      wrap_up,
  output logic                      wrap_down,
  output logic signed [EPOCH_W-1:0] epoch,
  output logic                      pm,
  output logic                      load_seen,
  output logic                      illegal_val,
  output logic                      illegal_step
);

  localparam logic [CNT_W-1:0]          MAX_V     = CNT_W'(MOD_MAX);
  localparam logic signed [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);

  trk_state_e                r_state;
  logic [CNT_W-1:0]          r_prev;
  logic                      r_load_q;
  logic                      r_wrap_up;
  logic                      r_wrap_down;
  logic signed [EPOCH_W-1:0] r_epoch;
  logic                      r_pm;
  logic                      r_load_seen;
  logic                      r_illegal_val;
  logic                      r_illegal_step;

  step_e w_step;
  logic  w_dout_bad;

  assign w_dout_bad = (dout > MAX_V);

  mod12_step_classifier #(
    .CNT_W   (CNT_W),
    .MOD_MAX (MOD_MAX)
  ) u_classifier (
    .i_prev   (r_prev),
    .i_dout   (dout),
    .i_load_q (r_load_q),
    .o_step   (w_step)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= ST_INIT;
      r_prev         <= '0;
      r_load_q       <= 1'b0;
      r_wrap_up      <= 1'b0;
      r_wrap_down    <= 1'b0;
      r_epoch        <= '0;
      r_pm           <= 1'b0;
      r_load_seen    <= 1'b0;
      r_illegal_val  <= 1'b0;
      r_illegal_step <= 1'b0;
    end else begin
      r_load_q       <= load;
      r_wrap_up      <= 1'b0;
      r_wrap_down    <= 1'b0;
      r_load_seen    <= 1'b0;
      // A clear on the same edge as a fresh error is overridden below.
      r_illegal_val  <= r_illegal_val & ~clr_err;
      r_illegal_step <= r_illegal_step & ~clr_err;

      if (w_dout_bad) begin
        r_illegal_val <= 1'b1;
        r_state       <= ST_INIT;
      end else if (r_state == ST_INIT) begin
        r_prev  <= dout;
        r_state <= ST_TRACK;
      end else begin
        r_prev <= dout;
        case (w_step)
          STEP_LOAD:    r_load_seen <= 1'b1;
          STEP_WRAP_UP: begin
            r_wrap_up <= 1'b1;
            r_epoch   <= r_epoch + EPOCH_ONE;
            r_pm      <= ~r_pm;
          end
          STEP_WRAP_DN: begin
            r_wrap_down <= 1'b1;
            r_epoch     <= r_epoch - EPOCH_ONE;
            r_pm        <= ~r_pm;
          end
          STEP_ILLEGAL: r_illegal_step <= 1'b1;
          default:      ;
        endcase
      end
    end
  end

  assign wrap_up      = r_wrap_up;
  assign wrap_down    = r_wrap_down;
  assign epoch        = r_epoch;
  assign pm           = r_pm;
  assign load_seen    = r_load_seen;
  assign illegal_val  = r_illegal_val;
  assign illegal_step = r_illegal_step;

endmodule

// File: tb/tb_mod12_wrap_tracker.sv
// Bench for mod12_wrap_tracker: directed scenarios plus a randomized run against a rule-level model.
module tb_mod12_wrap_tracker;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        dout = '0;
  logic              load = 1'b0;
  logic              clr_err = 1'b0;
  logic              wrap_up, wrap_down, pm, load_seen, illegal_val, illegal_step;
  logic signed [7:0] epoch;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, kept as plain integers.
  bit m_init, m_loadq, m_pm, m_wu, m_wd, m_ls, m_iv, m_is;
  int m_prev, m_epoch;

  mod12_wrap_tracker #(.CNT_W(4), .MOD_MAX(11), .EPOCH_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .dout         (dout),
    .load         (load),
    .clr_err      (clr_err),
    .wrap_up      (wrap_up),
    .wrap_down    (wrap_down),
    .epoch        (epoch),
    .pm           (pm),
    .load_seen    (load_seen),
    .illegal_val  (illegal_val),
    .illegal_step (illegal_step)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] obs_vec();
    return {wrap_up, wrap_down, load_seen, pm, illegal_val, illegal_step, epoch};
  endfunction

  function automatic logic [13:0] exp_vec();
    return {m_wu, m_wd, m_ls, m_pm, m_iv, m_is, 8'(m_epoch)};
  endfunction

  task automatic model_reset();
    m_init = 1; m_prev = 0; m_loadq = 0; m_epoch = 0; m_pm = 0;
    m_wu = 0; m_wd = 0; m_ls = 0; m_iv = 0; m_is = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; load = 1'b0; clr_err = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
  endtask

  // Drive one sample, clock it, and advance the model by the step rules.
  task automatic apply(input int d, input bit l, input bit c);
    @(negedge clk);
    rst = 1'b1; dout = 4'(d); load = l; clr_err = c;
    @(posedge clk);
    m_wu = 0; m_wd = 0; m_ls = 0;
    if (c) begin m_iv = 0; m_is = 0; end
    if (d > 11) begin
      m_iv = 1; m_init = 1;
    end else if (m_init) begin
      m_prev = d; m_init = 0;
    end else begin
      if (m_loadq) m_ls = 1;
      else if (d == m_prev) ;
      else if (m_prev == 11 && d == 0) begin m_wu = 1; m_epoch++; m_pm = !m_pm; end
      else if (m_prev == 0 && d == 11) begin m_wd = 1; m_epoch--; m_pm = !m_pm; end
      else if (d == m_prev + 1 || d == m_prev - 1) ;
      else m_is = 1;
      m_prev = d;
    end
    m_loadq = l;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (obs_vec() !== 14'd0) begin
      n_err++; $display("FAIL reset_outputs got=%h want=%h", obs_vec(), 14'd0);
    end
  endtask

  task automatic test_up_wrap();
    int nw = 0;
    do_reset();
    apply(0, 0, 0);
    for (int v = 1; v <= 11; v++) begin
      apply(v, 0, 0);
      nw += int'(wrap_up);
    end
    apply(0, 0, 0);
    nw += int'(wrap_up);
    n_vec++;
    if ({wrap_up, epoch, pm} !== {1'b1, 8'sd1, 1'b1}) begin
      n_err++; $display("FAIL up_wrap_pulse got=%b/%h/%b want=1/01/1", wrap_up, epoch, pm);
    end
    apply(1, 0, 0);
    nw += int'(wrap_up);
    n_vec++;
    if (wrap_up !== 1'b0 || nw != 1) begin
      n_err++; $display("FAIL up_wrap_once got=%b count=%0d want=0 count=1", wrap_up, nw);
    end
    n_vec++;
    if ({illegal_val, illegal_step, wrap_down} !== 3'b000) begin
      n_err++; $display("FAIL up_wrap_errs got=%b want=000", {illegal_val, illegal_step, wrap_down});
    end
  endtask

  task automatic test_down_wrap();
    do_reset();
    apply(2, 0, 0); apply(1, 0, 0); apply(0, 0, 0);
    apply(11, 0, 0);
    n_vec++;
    if ({wrap_down, wrap_up} !== 2'b10) begin
      n_err++; $display("FAIL down_wrap_pulse got=%b want=10", {wrap_down, wrap_up});
    end
    apply(10, 0, 0);
    n_vec++;
    if ({wrap_down, epoch, pm, illegal_step} !== {1'b0, 8'hFF, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL down_wrap_epoch got=%b/%h/%b/%b want=0/ff/1/0", wrap_down, epoch, pm, illegal_step);
    end
  endtask

  task automatic test_load();
    do_reset();
    apply(11, 0, 0);
    apply(11, 1, 0);
    apply(11, 0, 0);
    n_vec++;
    if ({load_seen, wrap_up, epoch} !== {1'b1, 1'b0, 8'h00}) begin
      n_err++; $display("FAIL load_same got=%b/%b/%h want=1/0/00", load_seen, wrap_up, epoch);
    end
    apply(0, 0, 0);
    n_vec++;
    if ({load_seen, wrap_up, epoch} !== {1'b0, 1'b1, 8'h01}) begin
      n_err++; $display("FAIL load_then_wrap got=%b/%b/%h want=0/1/01", load_seen, wrap_up, epoch);
    end
    do_reset();
    apply(5, 0, 0);
    apply(5, 1, 0);
    apply(9, 0, 0);
    n_vec++;
    if ({load_seen, illegal_step} !== 2'b10) begin
      n_err++; $display("FAIL load_jump got=%b want=10", {load_seen, illegal_step});
    end
    // A load step that looks like an up-wrap must not count as one.
    apply(11, 1, 0);
    apply(0, 0, 0);
    n_vec++;
    if ({load_seen, wrap_up, epoch} !== {1'b1, 1'b0, 8'h00}) begin
      n_err++; $display("FAIL load_masks_wrap got=%b/%b/%h want=1/0/00", load_seen, wrap_up, epoch);
    end
  endtask

  task automatic test_illegal_step();
    do_reset();
    apply(3, 0, 0); apply(7, 0, 0);
    n_vec++;
    if (illegal_step !== 1'b1) begin
      n_err++; $display("FAIL jump_flag got=%b want=1", illegal_step);
    end
    apply(8, 0, 0);
    n_vec++;
    if (illegal_step !== 1'b1) begin
      n_err++; $display("FAIL jump_sticky got=%b want=1", illegal_step);
    end
    apply(8, 0, 1);
    n_vec++;
    if (illegal_step !== 1'b0) begin
      n_err++; $display("FAIL jump_clear got=%b want=0", illegal_step);
    end
    apply(2, 0, 1);
    n_vec++;
    if (illegal_step !== 1'b1) begin
      n_err++; $display("FAIL jump_clear_collide got=%b want=1", illegal_step);
    end
  endtask

  task automatic test_illegal_val();
    do_reset();
    apply(2, 0, 0); apply(13, 0, 0);
    n_vec++;
    if ({illegal_val, illegal_step} !== 2'b10) begin
      n_err++; $display("FAIL bad_value got=%b want=10", {illegal_val, illegal_step});
    end
    apply(2, 0, 0);
    apply(3, 0, 0);
    n_vec++;
    if ({illegal_val, illegal_step, wrap_up, wrap_down} !== 4'b1000) begin
      n_err++; $display("FAIL bad_value_recover got=%b want=1000", {illegal_val, illegal_step, wrap_up, wrap_down});
    end
    apply(3, 0, 1);
    n_vec++;
    if (illegal_val !== 1'b0) begin
      n_err++; $display("FAIL bad_value_clear got=%b want=0", illegal_val);
    end
  endtask

  task automatic test_epoch_rollover();
    do_reset();
    apply(0, 0, 0);
    for (int w = 0; w < 128; w++) begin
      for (int v = 1; v <= 11; v++) apply(v, 0, 0);
      apply(0, 0, 0);
    end
    n_vec++;
    if ({epoch, pm} !== {8'h80, 1'b0}) begin
      n_err++; $display("FAIL epoch_128 got=%h/%b want=80/0", epoch, pm);
    end
    apply(1, 0, 0);
    do_reset();
    n_vec++;
    if (obs_vec() !== 14'd0) begin
      n_err++; $display("FAIL mid_reset got=%h want=%h", obs_vec(), 14'd0);
    end
    apply(0, 0, 0);
    n_vec++;
    if (obs_vec() !== 14'd0) begin
      n_err++; $display("FAIL first_after_reset got=%h want=%h", obs_vec(), 14'd0);
    end
  endtask

  task automatic test_random();
    int cur = 0;
    bit pend = 0;
    int pendv = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int r;
      int d;
      bit l, c;
      r = int'($urandom_range(99));
      c = ($urandom_range(19) == 0);
      if (r < 2) begin
        do_reset();
        pend = 0;
      end else begin
        if (pend) d = pendv;
        else if (r < 55) d = (cur + 1) % 12;
        else if (r < 78) d = (cur + 11) % 12;
        else if (r < 88) d = cur;
        else if (r < 94) d = int'($urandom_range(15));
        else d = cur;
        l = (r >= 94);
        pend = l;
        pendv = int'($urandom_range(12));
        apply(d, l, c);
        if (d <= 11) cur = d;
      end
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_illegal_step();
    test_illegal_val();
    test_epoch_rollover();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
